// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - op-code constants (4-bit control_in encoding)
//   - FSM state encoding for the top-level handshake controller
//   - helpers that classify op codes (iterative vs. single-cycle)
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1100;
    localparam logic [3:0] OP_MULHU = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_REMU  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // MUL, MULHU, DIVU, REMU all live in the 11xx corner of the op space;
    // the low two bits then select the flavour inside the iterative core.
    function automatic logic is_iterative(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

    function automatic logic is_divide(input logic [3:0] op);
        return op[3:1] == 3'b111;
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// alu_iter_core: one-bit-per-cycle multiply / unsigned divide datapath.
//   clk, reset (async, active-high), flush (sync abort)
//   start  : begin a new operation with operands a, b
//   kind   : 00 MUL low, 01 MULHU, 10 DIVU, 11 REMU
//   done   : high during the last iteration cycle; result is valid then
//   result : final value, computed from the last iteration's next state
// The operation runs for WIDTH cycles after start; the caller registers
// result on the edge where done is high.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             start,
    input  logic [1:0]       kind,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);

    logic               active_q, active_d;
    logic [1:0]         kind_q, kind_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor
    logic [2*WIDTH-1:0] acc_q, acc_d;     // product, or quotient in low half
    logic [WIDTH:0]     rem_q, rem_d;     // partial remainder

    // Shift-add multiply: add multiplicand into the top half when the
    // current multiplier bit (acc LSB) is set, then shift right by one.
    // The extra sum bit carries into the shifted-in MSB.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract; the borrow (bit WIDTH) tells whether the subtract fits.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_fits;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   quo_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_fits  = ~div_diff[WIDTH];
        rem_next  = div_fits ? div_diff : div_shift;
        quo_next  = {acc_q[WIDTH-2:0], div_fits};
    end

    assign done = active_q && (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        case (kind_q)
            2'b00:   result = mul_next[WIDTH-1:0];
            2'b01:   result = mul_next[2*WIDTH-1:WIDTH];
            2'b10:   result = quo_next;
            default: result = rem_next[WIDTH-1:0];
        endcase
    end

    always_comb begin
        active_d = active_q;
        kind_d   = kind_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        if (flush) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (start) begin
            active_d = 1'b1;
            kind_d   = kind;
            cnt_d    = '0;
            rem_d    = '0;
            if (kind[1]) begin
                opnd_d = b;
                acc_d  = {{WIDTH{1'b0}}, a};
            end else begin
                opnd_d = a;
                acc_d  = {{WIDTH{1'b0}}, b};
            end
        end else if (active_q) begin
            cnt_d = cnt_q + 1'b1;
            if (kind_q[1]) begin
                acc_d = {acc_q[2*WIDTH-1:WIDTH], quo_next};
                rem_d = rem_next;
            end else begin
                acc_d = mul_next;
            end
            if (done) begin
                active_d = 1'b0;
                cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            kind_q   <= '0;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
        end else begin
            active_q <= active_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV32 execute-stage ALU with valid/ready handshakes.
//   clk, reset (async, active-high), flush (sync abort, highest priority)
//   in_valid/in_ready, A, B, control_in : operand/op input handshake
//   out_valid/out_ready, ALU_out, zero  : registered result handshake
//   busy                                : iterative operation in progress
// Single-cycle ops (and divide by zero) complete on the accept edge;
// MUL/MULHU/DIVU/REMU are handed to alu_iter_core and take WIDTH more edges.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       control_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_out,
    output logic             zero,
    output logic             busy
);

    localparam int SHAMT_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic             div_by_zero;
    logic             iter_start;
    logic [WIDTH-1:0] quick_result;
    logic             core_done;
    logic [WIDTH-1:0] core_result;
    logic [SHAMT_W-1:0] shamt;

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_BUSY);
    assign out_valid = (state_q == ST_DONE);
    assign ALU_out   = alu_out_q;
    assign zero      = zero_q;

    assign shamt       = B[SHAMT_W-1:0];
    assign accept      = in_valid && in_ready && !flush;
    // Division by zero has a fixed answer, so it bypasses the iterative core.
    assign div_by_zero = is_divide(control_in) && (B == '0);
    assign iter_start  = accept && is_iterative(control_in) && !div_by_zero;

    always_comb begin
        case (control_in)
            OP_AND:   quick_result = A & B;
            OP_OR:    quick_result = A | B;
            OP_ADD:   quick_result = A + B;
            OP_SUB:   quick_result = A - B;
            OP_XOR:   quick_result = A ^ B;
            OP_SLL:   quick_result = A << shamt;
            OP_SRL:   quick_result = A >> shamt;
            OP_SRA:   quick_result = $unsigned($signed(A) >>> shamt);
            OP_SLT:   quick_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU:  quick_result = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_DIVU:  quick_result = '1;   // only reached with B == 0
            OP_REMU:  quick_result = A;    // only reached with B == 0
            default:  quick_result = '0;
        endcase
    end

    alu_iter_core #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .start  (iter_start),
        .kind   (control_in[1:0]),
        .a      (A),
        .b      (B),
        .done   (core_done),
        .result (core_result)
    );

    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out_q;
        zero_d    = zero_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (iter_start) begin
                            state_d = ST_BUSY;
                        end else begin
                            state_d   = ST_DONE;
                            alu_out_d = quick_result;
                            zero_d    = (quick_result == '0);
                        end
                    end
                end
                ST_BUSY: begin
                    if (core_done) begin
                        state_d   = ST_DONE;
                        alu_out_d = core_result;
                        zero_d    = (core_result == '0);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            alu_out_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            zero_q    <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  control_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALU_out;
    logic        zero;
    logic        busy;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_exp;

    alu_mc #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .control_in (control_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALU_out    (ALU_out),
        .zero       (zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the architectural definition.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] prod;
        int signed   sa, sb;
        prod = 64'(a) * 64'(b);
        sa = a;
        sb = b;
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0011: return a ^ b;
            4'b0100: return a << b[4:0];
            4'b0101: return a >> b[4:0];
            4'b1001: return sa >>> b[4:0];
            4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: return (a < b) ? 32'd1 : 32'd0;
            4'b1100: return prod[31:0];
            4'b1101: return prod[63:32];
            4'b1110: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'b1111: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'b1100 || op == 4'b1101) return 33;
        if ((op == 4'b1110 || op == 4'b1111) && b != 0) return 33;
        return 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one operation at a negedge; return #1 after its accept edge
    // with the inputs scrambled (the DUT must have latched them).
    task automatic accept_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        control_in = op;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        control_in = 4'($urandom);
        A = $urandom;
        B = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] exp;
        int          lat;
        int          edges;
        logic        busy_ok;
        exp = ref_alu(op, a, b);
        lat = ref_latency(op, b);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        accept_op(op, a, b);
        edges = 1;
        busy_ok = 1'b1;
        while (out_valid !== 1'b1 && edges < 100) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'(lat));
        check({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_result"}, ALU_out, exp);
        check({tag, "_zero"}, 32'(zero), 32'(exp == 0));
        $display("[TB] %s op=%b A=%08h B=%08h -> %08h zero=%0b latency=%0d",
                 tag, op, a, b, ALU_out, zero, edges);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_hs_ready"}, 32'(in_ready), 32'd1);
        last_exp = exp;
    endtask

    initial begin
        logic        ok;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        control_in = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_out", ALU_out, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 1. single-cycle ops
        run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1);
        run_op("sub_eq", OP_SUB, 32'd5, 32'd5);
        run_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1);
        run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        run_op("sra", OP_SRA, 32'h8000_0000, 32'd4);
        run_op("rsv1010", 4'b1010, 32'h1234_5678, 32'h9);
        // 2. iterative multiply
        run_op("mul", OP_MUL, 32'h0001_0000, 32'h0001_0000);
        run_op("mulhu", OP_MULHU, 32'h0001_0000, 32'h0001_0000);
        run_op("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        // 3. divide
        run_op("divu", OP_DIVU, 32'd100, 32'd7);
        run_op("remu", OP_REMU, 32'd100, 32'd7);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd1);
        run_op("divu_z", OP_DIVU, 32'hDEAD_BEEF, 32'd0);
        run_op("remu_z", OP_REMU, 32'h0000_1234, 32'd0);

        // 4. backpressure in DONE
        accept_op(OP_ADD, 32'd7, 32'd8);
        check("bp_valid", 32'(out_valid), 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            control_in = OP_SUB;
            A = $urandom;
            B = $urandom;
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || ALU_out !== 32'd15 || zero !== 1'b0 || in_ready !== 1'b0)
                ok = 1'b0;
        end
        check("bp_hold_stable", 32'(ok), 32'd1);
        $display("[TB] backpressure held 10 cycles ALU_out=%08h", ALU_out);
        @(negedge clk);
        control_in = OP_ADD;
        A = 32'd1;
        B = 32'd1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_hs_valid", 32'(out_valid), 32'd0);
        check("bp_hs_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_result", ALU_out, 32'd2);
        $display("[TB] post-backpressure ADD 1+1 -> %08h", ALU_out);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        last_exp = 32'd2;

        // 5. flush at iteration 12
        accept_op(OP_MUL, 32'h0000_0123, 32'h0000_0456);
        repeat (12) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        control_in = OP_ADD;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_in_ready", 32'(in_ready), 32'd1);
        check("fl_busy", 32'(busy), 32'd0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_alu_hold", ALU_out, last_exp);
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
        end
        check("fl_no_pulse", 32'(ok), 32'd1);
        $display("[TB] flush at iteration 12, in_ready=%0b", in_ready);
        run_op("fl_add", OP_ADD, 32'd2, 32'd3);

        // 6. async reset mid-BUSY
        accept_op(OP_DIVU, 32'd1000, 32'd7);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_alu_out", ALU_out, 32'd0);
        check("ar_zero", 32'(zero), 32'd0);
        $display("[TB] async reset mid-BUSY");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ar_in_ready", 32'(in_ready), 32'd1);
        run_op("ar_divu", OP_DIVU, 32'd9, 32'd3);

        // randomized sweep against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            run_op($sformatf("rnd%0d", i), rop, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
